// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308 scan controller.
// The config-word builder lives here so the bench-facing layout sits next to the bit constants.
package adc_pkg;

  localparam int RESULT_W = 12;
  localparam int CFG_W    = 6;
  localparam int CH_W     = 3;
  localparam int NUM_CH   = 8;

  localparam logic SD  = 1'b1;
  localparam logic UNI = 1'b1;
  localparam logic SLP = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    GAP,
    SHIFT,
    LATCH,
    PUSH
  } state_t;

  // LTC2308 word order: S/D, O/S, S1, S0, UNI, SLP; O/S carries the channel LSB
  function automatic logic [CFG_W-1:0] cfg_word(input logic [CH_W-1:0] ch);
    return {SD, ch[0], ch[2], ch[1], UNI, SLP};
  endfunction

endpackage

// File: rtl/adc_ch_select.sv
// Combinational round-robin picker: lowest enabled channel strictly above cur_ch,
// wrapping past 7; with only cur_ch enabled the search lands back on cur_ch.
module adc_ch_select
  import adc_pkg::*;
(
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   next_ch
);

  logic            w_found;
  logic [CH_W-1:0] w_idx;

  always_comb begin
    w_found = 1'b0;
    w_idx   = cur_ch;
    next_ch = cur_ch;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = cur_ch + CH_W'(i);
      if (!w_found && ch_mask[w_idx]) begin
        w_found = 1'b1;
        next_ch = w_idx;
      end
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// LTC2308 continuous scan controller: CONVST pulse, 12-bit SPI frame carrying the next
// channel's config, one-frame result pipeline, and a valid/ready result port with backpressure.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                adc_convst,
  output logic                adc_sclk,
  output logic                adc_din,
  input  logic                adc_dout,
  output logic                result_valid,
  output logic [CH_W-1:0]     result_ch,
  output logic [RESULT_W-1:0] result_data,
  input  logic                result_ready,
  output logic                busy
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_RISE   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CLK_DIV - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PH_W-1:0]     r_ph;
  logic [3:0]          r_bit;
  logic [CFG_W-1:0]    r_cfg_sr;
  logic [RESULT_W-1:0] r_shift;
  logic [CH_W-1:0]     r_cur_ch;
  logic [CH_W-1:0]     r_cfg_ch;
  logic [CH_W-1:0]     w_next_ch;
  logic                r_dummy;
  logic                r_valid;
  logic [CH_W-1:0]     r_res_ch;
  logic [RESULT_W-1:0] r_res_data;
  logic                w_run;
  logic                w_conv_done;
  logic                w_shift_done;

  assign w_run        = enable && (ch_mask != '0);
  assign w_conv_done  = (r_state == CONV) && (r_cnt == CONV_LAST);
  assign w_shift_done = (r_state == SHIFT) && (r_bit == 4'd11) && (r_ph == PH_LAST);

  // r_cfg_ch is the channel the ADC was last told to convert; the picker advances from it
  adc_ch_select u_ch_select (
    .ch_mask (ch_mask),
    .cur_ch  (r_cfg_ch),
    .next_ch (w_next_ch)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_run && !r_valid) w_next_state = CONV;
      CONV:    if (w_conv_done) w_next_state = GAP;
      GAP:     w_next_state = SHIFT;
      SHIFT:   if (w_shift_done) w_next_state = LATCH;
      LATCH: begin
        if (!r_dummy)   w_next_state = PUSH;
        else if (w_run) w_next_state = CONV;
        else            w_next_state = IDLE;
      end
      PUSH:    if (result_ready) w_next_state = w_run ? CONV : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_ph       <= '0;
      r_bit      <= '0;
      r_cfg_sr   <= '0;
      r_shift    <= '0;
      r_cur_ch   <= '0;
      r_cfg_ch   <= '0;
      r_dummy    <= 1'b1;
      r_valid    <= 1'b0;
      r_res_ch   <= '0;
      r_res_data <= '0;
    end else begin
      r_cnt <= (r_state == CONV) ? r_cnt + 1'b1 : '0;
      case (r_state)
        IDLE: r_dummy <= 1'b1;
        GAP: begin
          r_ph     <= '0;
          r_bit    <= '0;
          r_cfg_sr <= cfg_word(w_next_ch);
          r_cur_ch <= r_cfg_ch;
          r_cfg_ch <= w_next_ch;
        end
        SHIFT: begin
          if (r_ph == PH_RISE) r_shift <= {r_shift[RESULT_W-2:0], adc_dout};
          if (r_ph == PH_LAST) begin
            r_ph     <= '0;
            r_bit    <= r_bit + 1'b1;
            r_cfg_sr <= {r_cfg_sr[CFG_W-2:0], 1'b0};
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        LATCH: begin
          if (r_dummy) begin
            r_dummy <= 1'b0;
          end else begin
            r_res_ch   <= r_cur_ch;
            r_res_data <= r_shift;
            r_valid    <= 1'b1;
          end
        end
        PUSH: if (result_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // config bits drain out of r_cfg_sr, so bits 7..12 go out as zero without extra logic
  assign adc_convst   = (r_state == CONV);
  assign adc_sclk     = (r_state == SHIFT) && (r_ph >= PH_HIGH);
  assign adc_din      = (r_state == SHIFT) && r_cfg_sr[CFG_W-1];
  assign busy         = (r_state != IDLE);
  assign result_valid = r_valid;
  assign result_ch    = r_res_ch;
  assign result_data  = r_res_data;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: LTC2308 behavioural model plus a result scoreboard and config-word checks.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  ch_mask;
  logic        adc_convst;
  logic        adc_sclk;
  logic        adc_din;
  logic        adc_dout;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic [11:0] result_data;
  logic        result_ready;
  logic        busy;

  always #5 clk = ~clk;

  adc_scan_ctrl #(.CLK_DIV(2), .CONV_CYCLES(80)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .adc_convst   (adc_convst),
    .adc_sclk     (adc_sclk),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .result_data  (result_data),
    .result_ready (result_ready),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_err = 0;
  int n_frames = 0;
  int n_results = 0;
  int first_frames = 0;
  int base;
  logic [14:0] exp_q[$];
  logic [5:0]  cfg_q[$];
  logic [14:0] m_exp;
  logic [5:0]  m_cfg_exp;
  logic [11:0] m_sr = '0;
  logic [5:0]  m_word = '0;
  logic [2:0]  m_cfg_ch = '0;
  logic [2:0]  m_conv_ch = '0;
  int          m_k = 0;
  logic [2:0]  hch;
  logic [11:0] hdat;
  logic        ok;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] mdata(input logic [2:0] ch);
    return 12'hABC ^ {ch, 9'd0};
  endfunction

  // ADC model: converts the channel configured in the previous frame, shifts result MSB first
  assign adc_dout = m_sr[11];

  always @(posedge adc_convst) begin
    m_conv_ch = m_cfg_ch;
    m_sr = mdata(m_conv_ch);
    m_k = 0;
    n_frames++;
  end

  always @(posedge adc_sclk) begin
    if (m_k < 6) m_word = {m_word[4:0], adc_din};
    m_k++;
    if (m_k == 6) begin
      m_cfg_ch = {m_word[3], m_word[2], m_word[4]};
      if (cfg_q.size() > 0) begin
        m_cfg_exp = cfg_q.pop_front();
        check("cfg_word", 32'(m_word), 32'(m_cfg_exp));
      end
    end
    m_sr = {m_sr[10:0], 1'b0};
  end

  always @(negedge clk) begin
    if (reset_n && result_valid && result_ready) begin
      if (n_results == 0) first_frames = n_frames;
      if (exp_q.size() == 0) begin
        check("res_extra", 32'd1, 32'd0);
      end else begin
        m_exp = exp_q.pop_front();
        check("res_ch", 32'(result_ch), 32'(m_exp[14:12]));
        check("res_data", 32'(result_data), 32'(m_exp[11:0]));
      end
      n_results++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    exp_q.delete();
    cfg_q.delete();
    n_frames = 0;
    n_results = 0;
    first_frames = 0;
  endtask

  task automatic push_res(input logic [2:0] ch);
    exp_q.push_back({ch, mdata(ch)});
  endtask

  task automatic wait_results(input int n, input string tag);
    int c = 0;
    while (n_results < n && c < 4000) begin
      tick();
      c++;
    end
    check(tag, 32'(n_results >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 4000) begin
      tick();
      c++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    ch_mask = 8'h00;
    result_ready = 1'b1;
    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_convst", 32'(adc_convst), 32'd0);
    check("rst_sclk", 32'(adc_sclk), 32'd0);
    check("rst_din", 32'(adc_din), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_ch", 32'(result_ch), 32'd0);
    check("rst_data", 32'(result_data), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // single channel 0
    clr();
    for (int i = 0; i < 6; i++) push_res(3'd0);
    for (int i = 0; i < 8; i++) cfg_q.push_back(6'b100010);
    ch_mask = 8'h01;
    enable = 1'b1;
    wait_results(3, "t1_tmo");
    enable = 1'b0;
    wait_idle("t1_idle");
    check("t1_first", 32'(first_frames), 32'd2);
    check("t1_count", 32'(n_results), 32'd4);
    check("t1_frames", 32'(n_frames), 32'd5);

    // round robin over channels 2, 5, 7
    clr();
    push_res(3'd2); push_res(3'd5); push_res(3'd7);
    push_res(3'd2); push_res(3'd5); push_res(3'd7);
    for (int i = 0; i < 3; i++) begin
      cfg_q.push_back(6'b100110);
      cfg_q.push_back(6'b111010);
      cfg_q.push_back(6'b111110);
    end
    ch_mask = 8'b1010_0100;
    enable = 1'b1;
    wait_results(5, "t2_tmo");
    enable = 1'b0;
    wait_idle("t2_idle");
    check("t2_first", 32'(first_frames), 32'd2);
    check("t2_count", 32'(n_results), 32'd6);

    // backpressure
    clr();
    push_res(3'd0); push_res(3'd0); push_res(3'd0);
    ch_mask = 8'h01;
    result_ready = 1'b0;
    enable = 1'b1;
    begin
      int c = 0;
      while (!result_valid && c < 4000) begin
        tick();
        c++;
      end
    end
    check("t3_valid", 32'(result_valid), 32'd1);
    hch = result_ch;
    hdat = result_data;
    ok = 1'b1;
    check("t3_ch", 32'(result_ch), 32'd0);
    check("t3_data", 32'(result_data), 32'hABC);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!result_valid || result_ch !== hch || result_data !== hdat || adc_convst) ok = 1'b0;
    end
    check("t3_stable", 32'(ok), 32'd1);
    check("t3_frames", 32'(n_frames), 32'd2);
    tick();
    result_ready = 1'b1;
    tick();
    check("t3_conv_next", 32'(adc_convst), 32'd1);
    check("t3_valid_drop", 32'(result_valid), 32'd0);
    enable = 1'b0;
    wait_idle("t3_idle");
    check("t3_count", 32'(n_results), 32'd2);

    // reset in the middle of SHIFT
    clr();
    ch_mask = 8'h01;
    enable = 1'b1;
    begin
      int c = 0;
      while (!adc_sclk && c < 4000) begin
        tick();
        c++;
      end
    end
    check("t4_sclk_seen", 32'(adc_sclk), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_convst", 32'(adc_convst), 32'd0);
    check("t4_sclk", 32'(adc_sclk), 32'd0);
    check("t4_din", 32'(adc_din), 32'd0);
    check("t4_valid", 32'(result_valid), 32'd0);
    check("t4_ch", 32'(result_ch), 32'd0);
    check("t4_data", 32'(result_data), 32'd0);
    tick(); tick();
    clr();
    push_res(3'd0); push_res(3'd0); push_res(3'd0);
    reset_n = 1'b1;
    wait_results(1, "t4_tmo");
    enable = 1'b0;
    wait_idle("t4_idle");
    check("t4_first", 32'(first_frames), 32'd2);
    check("t4_count", 32'(n_results), 32'd2);

    // empty mask keeps the block idle
    clr();
    ch_mask = 8'h00;
    enable = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy || adc_convst || adc_sclk) ok = 1'b0;
    end
    check("t5_idle", 32'(ok), 32'd1);
    enable = 1'b0;

    // enable dropped 10 cycles into a non-dummy CONV
    tick();
    clr();
    push_res(3'd0); push_res(3'd0); push_res(3'd0);
    ch_mask = 8'h01;
    enable = 1'b1;
    wait_results(1, "t6_tmo");
    check("t6_in_conv", 32'(adc_convst), 32'd1);
    repeat (9) @(posedge clk);
    #1;
    check("t6_conv10", 32'(adc_convst), 32'd1);
    enable = 1'b0;
    base = n_results;
    wait_idle("t6_idle");
    check("t6_one", 32'(n_results - base), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy || adc_convst) ok = 1'b0;
    end
    check("t6_stay_idle", 32'(ok), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, setting the SCLK half-period in clk cycles (12.5 MHz SCLK at 50 MHz).
REQ-002 The block SHALL have parameter CONV_CYCLES, default 80, setting the CONVST-high conversion window in clk cycles (1.6 us at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, driven from CLOCK_50.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: run continuous scanning while high.
REQ-006 The block SHALL have port ch_mask, input, 8 bits: bit n set means channel n is in the scan list.
REQ-007 The block SHALL have port adc_convst, output, 1 bit: drives ADC_CS_N, which is LTC2308 CONVST.
REQ-008 The block SHALL have port adc_sclk, output, 1 bit: drives ADC_SCLK.
REQ-009 The block SHALL have port adc_din, output, 1 bit: drives ADC_DIN, the serial config word.
REQ-010 The block SHALL have port adc_dout, input, 1 bit: from ADC_DOUT, the serial result.
REQ-011 The block SHALL have ports result_valid (output, 1 bit), result_ch (output, 3 bits) and result_data (output, 12 bits), forming the result channel.
REQ-012 The block SHALL have port result_ready, input, 1 bit: consumer accept.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, CONV, GAP, SHIFT, LATCH and PUSH.
REQ-015 IDLE -> CONV SHALL occur when enable=1, ch_mask!=0 and result_valid=0.
REQ-016 In CONV, adc_convst SHALL be 1 for exactly CONV_CYCLES cycles; the FSM then goes to GAP.
REQ-017 In GAP, adc_convst SHALL be 0 for 1 cycle; the FSM then goes to SHIFT.
REQ-018 SHIFT SHALL run 12 SCLK periods of 2*CLK_DIV cycles each: sclk is low for the first CLK_DIV cycles and high for the next CLK_DIV; sclk idles at 0.
REQ-019 adc_din SHALL update at the start of each low phase, MSB first, for bits 1..6; for bits 7..12 adc_din SHALL be 0.
REQ-020 adc_dout SHALL be sampled on the clk edge where sclk rises and shifted MSB-first into a 12-bit register.
REQ-021 The config word SHALL be {S/D=1, O/S=next_ch[0], S1=next_ch[2], S0=next_ch[1], UNI=1, SLP=0}, for example ch0=100010 and ch5=111010.
REQ-022 next_ch SHALL be chosen at SHIFT entry as the lowest set ch_mask bit strictly above the current channel, wrapping from 7 to 0.
REQ-023 The shifted result SHALL belong to the channel configured in the previous frame (one-frame pipeline); that channel SHALL be tracked as cur_ch.
REQ-024 LATCH (1 cycle) SHALL capture cur_ch and the shift register into result_ch/result_data, then go to PUSH, except for a dummy frame.
REQ-025 The first frame after leaving IDLE SHALL be a dummy: its result is discarded, result_valid is not raised, and the FSM goes directly to CONV.
REQ-026 PUSH SHALL hold result_valid=1 with result_ch/result_data stable until result_ready=1; valid and ready in the same cycle means transfer.
REQ-027 After a transfer, the FSM SHALL go to CONV if enable=1 and ch_mask!=0, else to IDLE.
REQ-028 A new conversion SHALL NOT start while a result is unaccepted; this is backpressure, and results are never dropped.
REQ-029 Deasserting enable mid-frame SHALL let the frame complete and its result be delivered (if not a dummy) before returning to IDLE.
REQ-030 If ch_mask becomes 0 mid-frame, the current frame SHALL complete and the FSM SHALL then go to IDLE.
REQ-031 A ch_mask change SHALL take effect at the next SHIFT entry.
REQ-032 Frame period without stall SHALL be CONV_CYCLES + 1 + 24*CLK_DIV + 1 cycles, which is 130 with defaults.

Reset
REQ-033 reset_n=0 SHALL asynchronously force state=IDLE, adc_convst=0, adc_sclk=0, adc_din=0, result_valid=0, result_ch=0, result_data=0, busy=0, cur_ch=0, and set the dummy flag.
REQ-034 Reset mid-frame SHALL abandon the frame; the next start after reset SHALL be a dummy frame.

Structure
REQ-035 Package adc_pkg SHALL hold the FSM state enum, the config-bit constants (SD, UNI, SLP), RESULT_W=12, CFG_W=6 and CH_W=3.
REQ-036 Sub-module adc_ch_select SHALL implement the combinational round-robin next-channel picker (inputs ch_mask and cur_ch; output next_ch).
REQ-037 Target size SHALL be approximately 200 lines of RTL.

Verification
REQ-038 With ch_mask=8'h01, enable=1 and an ADC model returning 12'hABC: the first frame gives no valid; from the second frame result_valid=1, result_ch=0, result_data=12'hABC; adc_din=100010 every frame.
REQ-039 With ch_mask=8'b10100100: result_ch SHALL sequence 2,5,7,2,5; the frame config words SHALL be 100110, 111010, 111110.
REQ-040 With result_ready held 0 for 500 cycles: result_valid, result_ch and result_data SHALL stay stable and adc_convst SHALL stay 0; on ready=1, CONV SHALL start the next cycle.
REQ-041 With reset_n pulsed low during SHIFT: all outputs SHALL be 0 immediately; after release with enable=1, a dummy frame SHALL precede the first valid result.
REQ-042 With enable=1 and ch_mask=0: the block SHALL stay in IDLE with busy=0, adc_convst=0 and adc_sclk=0 for 1000 cycles.
REQ-043 With enable dropped 10 cycles into CONV of a non-dummy frame: exactly one result SHALL be delivered, then busy=0.
